cache_ctrl: RTL and testbench
=============================

# cache_ctrl

2-way set-associative write-back/write-allocate data-cache controller. Sequences two cache-way arrays (tag, valid, dirty, 4-bank data and LRU per set) between a single-outstanding CPU load/store port and a line-granular memory port. Handles the hit, victim write-back and refill sequences; the two ways and this controller together form the D-cache.

## Interface
Parameters:
- `IDX_W`, 8: index width (256 sets).
- `TAG_W`, 20: tag width.
- `OFF_W`, 4: byte offset in a 16-byte line (4 banks x 32 bits).

Ports. Clock is `clk`, reset is `rst_n`. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid_i`  in  1  CPU request
- `req_ready_o`  out  1  request accepted when valid&ready
- `req_we_i`  in  1  1=store
- `req_addr_i`  in  32  byte address = {tag, index, offset}
- `req_wstrb_i`  in  4  store byte enables
- `req_wdata_i`  in  32  store data
- `resp_valid_o`  out  1  one-cycle pulse: load data valid / store done
- `resp_rdata_o`  out  32  load data
- `way_index_o`  out  IDX_W  index to both ways
- `way_offset_o`  out  OFF_W  offset to both ways
- `way_wr_tag_en_o`, `way_wr_valid_en_o`, `way_wr_dirty_en_o`, `way_wr_full_bank_o`  out  2 each  per-way write enables
- `way_wr_data_en_o`  out  8  per-way 4-bit bank enables, way1 in [7:4]
- `way_wr_lru_en_o`  out  1  LRU write (LRU bit held in way 0 only)
- `way_wr_tag_o` / `way_wr_valid_o` / `way_wr_dirty_o` / `way_wr_data_o` / `way_wr_lru_o`  out  TAG_W/1/1/128/1  shared write data
- `way0_rd_tag_i`, `way1_rd_tag_i`  in  TAG_W; `way0_rd_valid_i`, `way1_rd_valid_i`, `way0_rd_dirty_i`, `way1_rd_dirty_i`  in  1 each; `way0_rd_data_i`, `way1_rd_data_i`  in  128 each; `way0_rd_lru_i`  in  1.
- `mem_rd_req_o`  out  1; `mem_rd_addr_o`  out  32 (line-aligned); `mem_rd_ready_i`  in  1
- `mem_ret_valid_i`  in  1; `mem_ret_data_i`  in  128  full refill line
- `mem_wr_req_o`  out  1; `mem_wr_addr_o`  out  32; `mem_wr_data_o`  out  128; `mem_wr_ready_i`  in  1
- `hit_cnt_o`, `miss_cnt_o`  out  32  performance counters

## Operation
- Way arrays read synchronously: an index driven in cycle N returns data in N+1.
- IDLE: `req_ready_o`=1. On accept, register the request, drive the index, go to LOOKUP.
- LOOKUP: hit_w = valid_w & (tag_w == req tag). A hit in both ways cannot occur; if it does, way 0 wins.
  - Load hit: `resp_rdata_o` = bank offset[3:2] of the hit way. Pulse `resp_valid_o`. Write LRU = ~w. Go to IDLE.
  - Store hit: merge `req_wstrb_i` bytes into the read word and replicate it across all 4 lanes of `way_wr_data_o`. Set the single bank enable, set dirty=1, write LRU = ~w, pulse `resp_valid_o`, go to IDLE.
  - Miss: victim = first invalid way (way 0 preferred), else way `way0_rd_lru_i`. Latch the victim tag, dirty bit and data. If the victim is valid and dirty, go to WB, else go to RD_REQ.
- WB: hold `mem_wr_req_o`, address {victim tag, index, 4'b0}, latched data, until `mem_wr_ready_i`. Then go to RD_REQ.
- RD_REQ: hold `mem_rd_req_o` until `mem_rd_ready_i`. Then go to RD_WAIT.
- RD_WAIT: on `mem_ret_valid_i`, write the victim way: full line (`way_wr_full_bank_o`), tag, valid=1, dirty=0. Go to LOOKUP (replay), which now hits.
- Memory request outputs are registered and must stay stable while the request is unacked.

## Timing
- Reset values: state IDLE, `req_ready_o`=1, every other output 0, counters 0.
- Hit latency: accept in cycle N, `resp_valid_o` in N+1.
- Clean miss latency: N+1 LOOKUP, then RD_REQ ≥1 cycle, then RD_WAIT until return, then the refill-write cycle, then replay LOOKUP with the response. Minimum 5 cycles when the memory acks and returns immediately.
- A dirty miss adds WB (≥1 cycle) before RD_REQ.
- `req_ready_o`=0 in every state except IDLE. No back-to-back accept in the response cycle.
- Reset asserted mid-sequence aborts the operation immediately. No partial line write is retried after reset.

## Configuration
- `CACHE_PERF_CNT_EN` defined: `hit_cnt_o` increments on each first-pass LOOKUP hit. `miss_cnt_o` increments on each first-pass miss. Replay hits are not counted. Both counters wrap at 2^32.
- `CACHE_PERF_CNT_EN` undefined: no counter flops; both outputs are tied to 0.

## Test plan
- Cold load to 0x0000_1234: miss → RD_REQ with address 0x0000_1230 → return line {D,C,B,A} → refill way 0 → `resp_rdata_o`=B (bank 1), miss_cnt=1.
- Repeat the load to 0x1234 → response in the next cycle with data B, no memory traffic, hit_cnt=1, LRU=1.
- Store 0xAABBCCDD with wstrb 4'b0011 to 0x1234 → bank 1 of way 0 becomes {B[31:16],CCDD}, dirty=1, only `way_wr_data_en_o`[1] set.
- Load to 0x0010_1234, then 0x0020_1234 (same set): the second load evicts dirty way 0 → write-back to 0x0000_1230 carrying the merged line, then refill.
- Hold `mem_wr_ready_i`/`mem_rd_ready_i` low for 10 cycles → request address and data stay stable, `req_ready_o`=0 throughout.
- Deassert `rst_n` during RD_WAIT → all outputs return to reset values; the next request starts a fresh lookup.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU load/store port and line-granular memory port.
// master = requester/memory side, slave = cache controller.
interface cache_ctrl_if;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_we_i;
   logic [31:0]   req_addr_i;
   logic [3:0]    req_wstrb_i;
   logic [31:0]   req_wdata_i;
   logic          resp_valid_o;
   logic [31:0]   resp_rdata_o;
   logic          mem_rd_req_o;
   logic [31:0]   mem_rd_addr_o;
   logic          mem_rd_ready_i;
   logic          mem_ret_valid_i;
   logic [127:0]  mem_ret_data_i;
   logic          mem_wr_req_o;
   logic [31:0]   mem_wr_addr_o;
   logic [127:0]  mem_wr_data_o;
   logic          mem_wr_ready_i;

   modport master (
      output req_valid_i, req_we_i, req_addr_i,
      output req_wstrb_i, req_wdata_i,
      output mem_rd_ready_i, mem_ret_valid_i,
      output mem_ret_data_i, mem_wr_ready_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o,
      input  mem_rd_req_o, mem_rd_addr_o,
      input  mem_wr_req_o, mem_wr_addr_o, mem_wr_data_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i,
      input  req_wstrb_i, req_wdata_i,
      input  mem_rd_ready_i, mem_ret_valid_i,
      input  mem_ret_data_i, mem_wr_ready_i,
      output req_ready_o, resp_valid_o, resp_rdata_o,
      output mem_rd_req_o, mem_rd_addr_o,
      output mem_wr_req_o, mem_wr_addr_o, mem_wr_data_o
   );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: 2-way set-associative write-back/write-allocate D-cache FSM.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module cache_ctrl #(
   parameter int IDX_W = 8,
   parameter int TAG_W = 20,
   parameter int OFF_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   cache_ctrl_if.slave      bus,
   output logic [IDX_W-1:0] way_index_o,
   output logic [OFF_W-1:0] way_offset_o,
   output logic [1:0]       way_wr_tag_en_o,
   output logic [1:0]       way_wr_valid_en_o,
   output logic [1:0]       way_wr_dirty_en_o,
   output logic [1:0]       way_wr_full_bank_o,
   output logic [7:0]       way_wr_data_en_o,
   output logic             way_wr_lru_en_o,
   output logic [TAG_W-1:0] way_wr_tag_o,
   output logic             way_wr_valid_o,
   output logic             way_wr_dirty_o,
   output logic [127:0]     way_wr_data_o,
   output logic             way_wr_lru_o,
   input  logic [TAG_W-1:0] way0_rd_tag_i,
   input  logic [TAG_W-1:0] way1_rd_tag_i,
   input  logic             way0_rd_valid_i,
   input  logic             way1_rd_valid_i,
   input  logic             way0_rd_dirty_i,
   input  logic             way1_rd_dirty_i,
   input  logic [127:0]     way0_rd_data_i,
   input  logic [127:0]     way1_rd_data_i,
   input  logic             way0_rd_lru_i,
   output logic [31:0]      hit_cnt_o,
   output logic [31:0]      miss_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB, S_RD_REQ, S_RD_WAIT, S_REFILL
   } state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          victim_q, victim_d;
   logic          replay_q, replay_d;
   logic [127:0]  line_q, line_d;
   logic          mrd_req_q, mrd_req_d;
   logic [31:0]   mrd_addr_q, mrd_addr_d;
   logic          mwr_req_q, mwr_req_d;
   logic [31:0]   mwr_addr_q, mwr_addr_d;
   logic [127:0]  mwr_data_q, mwr_data_d;

   logic [TAG_W-1:0] tag_q;
   logic [IDX_W-1:0] idx_q;
   logic [1:0]       bank;
   logic             hit0, hit1, any_hit, hit_way;
   logic [127:0]     hit_line;
   logic [31:0]      hit_word, merged;
   logic             vic, vic_valid, vic_dirty;
   logic [TAG_W-1:0] vic_tag;
   logic [127:0]     vic_data;

   assign tag_q = addr_q[31 -: TAG_W];
   assign idx_q = addr_q[OFF_W +: IDX_W];
   assign bank  = addr_q[3:2];

   // Way 0 wins if both ways claim a hit.
   assign hit0    = way0_rd_valid_i && (way0_rd_tag_i == tag_q);
   assign hit1    = !hit0 && way1_rd_valid_i && (way1_rd_tag_i == tag_q);
   assign any_hit = hit0 || hit1;
   assign hit_way = hit1;
   assign hit_line = hit_way ? way1_rd_data_i : way0_rd_data_i;
   assign hit_word = hit_line[{bank, 5'b0} +: 32];

   // Victim: first invalid way, way 0 first, else the LRU way.
   assign vic = !way0_rd_valid_i ? 1'b0 :
                !way1_rd_valid_i ? 1'b1 : way0_rd_lru_i;
   assign vic_valid = vic ? way1_rd_valid_i : way0_rd_valid_i;
   assign vic_dirty = vic ? way1_rd_dirty_i : way0_rd_dirty_i;
   assign vic_tag   = vic ? way1_rd_tag_i : way0_rd_tag_i;
   assign vic_data  = vic ? way1_rd_data_i : way0_rd_data_i;

   // Byte-merge store data into the word read from the hit way.
   always_comb begin
      merged = hit_word;
      for (int b = 0; b < 4; b++) begin
         if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   // Next-state, request capture and way/CPU output decode.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wstrb_d    = wstrb_q;
      wdata_d    = wdata_q;
      victim_d   = victim_q;
      replay_d   = replay_q;
      line_d     = line_q;
      mrd_req_d  = mrd_req_q;
      mrd_addr_d = mrd_addr_q;
      mwr_req_d  = mwr_req_q;
      mwr_addr_d = mwr_addr_q;
      mwr_data_d = mwr_data_q;
      bus.req_ready_o    = 1'b0;
      bus.resp_valid_o   = 1'b0;
      bus.resp_rdata_o   = '0;
      way_index_o        = idx_q;
      way_offset_o       = addr_q[OFF_W-1:0];
      way_wr_tag_en_o    = '0;
      way_wr_valid_en_o  = '0;
      way_wr_dirty_en_o  = '0;
      way_wr_full_bank_o = '0;
      way_wr_data_en_o   = '0;
      way_wr_lru_en_o    = 1'b0;
      way_wr_tag_o       = '0;
      way_wr_valid_o     = 1'b0;
      way_wr_dirty_o     = 1'b0;
      way_wr_data_o      = '0;
      way_wr_lru_o       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            bus.req_ready_o = 1'b1;
            way_index_o     = '0;
            way_offset_o    = '0;
            replay_d        = 1'b0;
            if (bus.req_valid_i) begin
               we_d         = bus.req_we_i;
               addr_d       = bus.req_addr_i;
               wstrb_d      = bus.req_wstrb_i;
               wdata_d      = bus.req_wdata_i;
               way_index_o  = bus.req_addr_i[OFF_W +: IDX_W];
               way_offset_o = bus.req_addr_i[OFF_W-1:0];
               state_d      = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (any_hit) begin
               bus.resp_valid_o = 1'b1;
               way_wr_lru_en_o  = 1'b1;
               way_wr_lru_o     = !hit_way;
               state_d          = S_IDLE;
               if (!we_q) begin
                  bus.resp_rdata_o = hit_word;
               end else begin
                  way_wr_data_o = {4{merged}};
                  way_wr_data_en_o[{hit_way, bank}] = 1'b1;
                  way_wr_dirty_en_o[hit_way] = 1'b1;
                  way_wr_dirty_o = 1'b1;
               end
            end else begin
               victim_d = vic;
               if (vic_valid && vic_dirty) begin
                  mwr_req_d  = 1'b1;
                  mwr_addr_d = {vic_tag, idx_q, {OFF_W{1'b0}}};
                  mwr_data_d = vic_data;
                  state_d    = S_WB;
               end else begin
                  mrd_req_d  = 1'b1;
                  mrd_addr_d = {tag_q, idx_q, {OFF_W{1'b0}}};
                  state_d    = S_RD_REQ;
               end
            end
         end
         S_WB: begin
            if (bus.mem_wr_ready_i) begin
               mwr_req_d  = 1'b0;
               mwr_addr_d = '0;
               mwr_data_d = '0;
               mrd_req_d  = 1'b1;
               mrd_addr_d = {tag_q, idx_q, {OFF_W{1'b0}}};
               state_d    = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (bus.mem_rd_ready_i) begin
               mrd_req_d  = 1'b0;
               mrd_addr_d = '0;
               state_d    = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (bus.mem_ret_valid_i) begin
               line_d  = bus.mem_ret_data_i;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            way_wr_full_bank_o[victim_q] = 1'b1;
            way_wr_tag_en_o[victim_q]    = 1'b1;
            way_wr_valid_en_o[victim_q]  = 1'b1;
            way_wr_dirty_en_o[victim_q]  = 1'b1;
            way_wr_tag_o   = tag_q;
            way_wr_valid_o = 1'b1;
            way_wr_data_o  = line_q;
            replay_d       = 1'b1;
            state_d        = S_LOOKUP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, request and memory-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
         victim_q   <= 1'b0;
         replay_q   <= 1'b0;
         line_q     <= '0;
         mrd_req_q  <= 1'b0;
         mrd_addr_q <= '0;
         mwr_req_q  <= 1'b0;
         mwr_addr_q <= '0;
         mwr_data_q <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wstrb_q    <= wstrb_d;
         wdata_q    <= wdata_d;
         victim_q   <= victim_d;
         replay_q   <= replay_d;
         line_q     <= line_d;
         mrd_req_q  <= mrd_req_d;
         mrd_addr_q <= mrd_addr_d;
         mwr_req_q  <= mwr_req_d;
         mwr_addr_q <= mwr_addr_d;
         mwr_data_q <= mwr_data_d;
      end
   end

   assign bus.mem_rd_req_o  = mrd_req_q;
   assign bus.mem_rd_addr_o = mrd_addr_q;
   assign bus.mem_wr_req_o  = mwr_req_q;
   assign bus.mem_wr_addr_o = mwr_addr_q;
   assign bus.mem_wr_data_o = mwr_data_q;

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Count first-pass lookups only; the post-refill replay is skipped.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == S_LOOKUP && !replay_q) begin
         if (any_hit) hit_cnt_d = hit_cnt_q + 32'd1;
         else         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   // Counter registers, wrapping naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench with behavioural way arrays and a
// memory responder with programmable ready stalls.
module tb_cache_ctrl;
`ifdef CACHE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [31:0] A = 32'h0123_4567;
   localparam logic [31:0] B = 32'h89AB_CDEF;
   localparam logic [31:0] C = 32'h1357_9BDF;
   localparam logic [31:0] D = 32'h2468_ACE0;

   logic clk, rst_n;
   cache_ctrl_if bus();

   logic [7:0]   way_index_o;
   logic [3:0]   way_offset_o;
   logic [1:0]   way_wr_tag_en_o, way_wr_valid_en_o;
   logic [1:0]   way_wr_dirty_en_o, way_wr_full_bank_o;
   logic [7:0]   way_wr_data_en_o;
   logic         way_wr_lru_en_o;
   logic [19:0]  way_wr_tag_o;
   logic         way_wr_valid_o, way_wr_dirty_o, way_wr_lru_o;
   logic [127:0] way_wr_data_o;
   logic [19:0]  way0_rd_tag_i, way1_rd_tag_i;
   logic         way0_rd_valid_i, way1_rd_valid_i;
   logic         way0_rd_dirty_i, way1_rd_dirty_i;
   logic [127:0] way0_rd_data_i, way1_rd_data_i;
   logic         way0_rd_lru_i;
   logic [31:0]  hit_cnt_o, miss_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   cache_ctrl dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .way_index_o(way_index_o), .way_offset_o(way_offset_o),
      .way_wr_tag_en_o(way_wr_tag_en_o),
      .way_wr_valid_en_o(way_wr_valid_en_o),
      .way_wr_dirty_en_o(way_wr_dirty_en_o),
      .way_wr_full_bank_o(way_wr_full_bank_o),
      .way_wr_data_en_o(way_wr_data_en_o),
      .way_wr_lru_en_o(way_wr_lru_en_o),
      .way_wr_tag_o(way_wr_tag_o), .way_wr_valid_o(way_wr_valid_o),
      .way_wr_dirty_o(way_wr_dirty_o), .way_wr_data_o(way_wr_data_o),
      .way_wr_lru_o(way_wr_lru_o),
      .way0_rd_tag_i(way0_rd_tag_i), .way1_rd_tag_i(way1_rd_tag_i),
      .way0_rd_valid_i(way0_rd_valid_i), .way1_rd_valid_i(way1_rd_valid_i),
      .way0_rd_dirty_i(way0_rd_dirty_i), .way1_rd_dirty_i(way1_rd_dirty_i),
      .way0_rd_data_i(way0_rd_data_i), .way1_rd_data_i(way1_rd_data_i),
      .way0_rd_lru_i(way0_rd_lru_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Way arrays: index registered, read data follows the registered index.
   logic [19:0]  m_tag   [2][256];
   logic         m_valid [2][256] = '{default: 1'b0};
   logic         m_dirty [2][256] = '{default: 1'b0};
   logic [127:0] m_data  [2][256];
   logic         m_lru   [256] = '{default: 1'b0};
   logic [7:0]   idx_r = '0;

   always @(posedge clk) begin
      idx_r <= way_index_o;
      for (int w = 0; w < 2; w++) begin
         if (way_wr_tag_en_o[w])   m_tag[w][way_index_o]   <= way_wr_tag_o;
         if (way_wr_valid_en_o[w]) m_valid[w][way_index_o] <= way_wr_valid_o;
         if (way_wr_dirty_en_o[w]) m_dirty[w][way_index_o] <= way_wr_dirty_o;
         if (way_wr_full_bank_o[w]) begin
            m_data[w][way_index_o] <= way_wr_data_o;
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (way_wr_data_en_o[4*w+b])
                  m_data[w][way_index_o][32*b +: 32] <= way_wr_data_o[32*b +: 32];
            end
         end
      end
      if (way_wr_lru_en_o) m_lru[way_index_o] <= way_wr_lru_o;
   end

   assign way0_rd_tag_i   = m_tag[0][idx_r];
   assign way1_rd_tag_i   = m_tag[1][idx_r];
   assign way0_rd_valid_i = m_valid[0][idx_r];
   assign way1_rd_valid_i = m_valid[1][idx_r];
   assign way0_rd_dirty_i = m_dirty[0][idx_r];
   assign way1_rd_dirty_i = m_dirty[1][idx_r];
   assign way0_rd_data_i  = m_data[0][idx_r];
   assign way1_rd_data_i  = m_data[1][idx_r];
   assign way0_rd_lru_i   = m_lru[idx_r];

   // Memory responder: ready after N stalled cycles, line returned next cycle.
   int           wr_delay = 0, rd_delay = 0, wr_wait = 0, rd_wait = 0;
   bit           hold_ret = 0;
   logic [127:0] ret_line = '0;
   int           wr_cnt = 0, rd_cnt = 0, ret_done = 0;
   logic [31:0]  wr_addr_log = '0, rd_addr_log = '0;
   logic [127:0] wr_data_log = '0;

   always @(negedge clk) begin
      bus.mem_ret_valid_i = 1'b0;
      if (rd_cnt != ret_done) begin
         ret_done = rd_cnt;
         if (!hold_ret) begin
            bus.mem_ret_valid_i = 1'b1;
            bus.mem_ret_data_i  = ret_line;
         end
      end
      if (bus.mem_wr_req_o) begin
         bus.mem_wr_ready_i = (wr_wait >= wr_delay);
         wr_wait++;
      end else begin
         bus.mem_wr_ready_i = 1'b0;
         wr_wait = 0;
      end
      if (bus.mem_rd_req_o) begin
         bus.mem_rd_ready_i = (rd_wait >= rd_delay);
         rd_wait++;
      end else begin
         bus.mem_rd_ready_i = 1'b0;
         rd_wait = 0;
      end
   end

   always @(posedge clk) begin
      if (bus.mem_wr_req_o && bus.mem_wr_ready_i) begin
         wr_cnt++;
         wr_addr_log = bus.mem_wr_addr_o;
         wr_data_log = bus.mem_wr_data_o;
      end
      if (bus.mem_rd_req_o && bus.mem_rd_ready_i) begin
         rd_cnt++;
         rd_addr_log = bus.mem_rd_addr_o;
      end
   end

   task automatic cpu(input logic we, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic [7:0] den,
                      output int lat, output int rdy_bad);
      rd = '0; den = '0; lat = 0; rdy_bad = 0;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = we;
      bus.req_addr_i = a; bus.req_wstrb_i = s; bus.req_wdata_i = d;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.req_ready_o) rdy_bad++;
         if (bus.resp_valid_o) begin
            lat = i; rd = bus.resp_rdata_o; den = way_wr_data_en_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cpu: ready=%b resp=%b want 1/0",
                  bus.req_ready_o, bus.resp_valid_o);
      end
      n_tests++;
      if (bus.mem_rd_req_o !== 1'b0 || bus.mem_wr_req_o !== 1'b0 ||
          bus.mem_rd_addr_o !== 32'h0 || bus.mem_wr_data_o !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_mem: rd=%b wr=%b addr=%h want zeros",
                  bus.mem_rd_req_o, bus.mem_wr_req_o, bus.mem_rd_addr_o);
      end
      n_tests++;
      if (way_index_o !== 8'h0 || way_wr_data_en_o !== 8'h0 ||
          way_wr_full_bank_o !== 2'b0 || way_wr_lru_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_way: idx=%h den=%h fb=%b lru=%b want zeros",
                  way_index_o, way_wr_data_en_o, way_wr_full_bank_o,
                  way_wr_lru_en_o);
      end
      n_tests++;
      if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cnt: hit=%0d miss=%0d want 0/0",
                  hit_cnt_o, miss_cnt_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_cold_load();
      logic [31:0] rd; logic [7:0] den; int lat, rb;
      ret_line = {D, C, B, A};
      cpu(1'b0, 32'h0000_1234, 4'h0, 32'h0, rd, den, lat, rb);
      n_tests++;
      if (lat !== 5 || rd !== B) begin
         n_fail++;
         $display("FAIL cold_load: lat=%0d data=%h want 5/%h", lat, rd, B);
      end
      n_tests++;
      if (rd_addr_log !== 32'h0000_1230 || rd_cnt !== 1 || wr_cnt !== 0) begin
         n_fail++;
         $display("FAIL cold_mem: addr=%h rd=%0d wr=%0d want 00001230/1/0",
                  rd_addr_log, rd_cnt, wr_cnt);
      end
      n_tests++;
      if (m_valid[0][8'h23] !== 1'b1 || m_tag[0][8'h23] !== 20'h1 ||
          m_dirty[0][8'h23] !== 1'b0) begin
         n_fail++;
         $display("FAIL cold_refill: v=%b tag=%h d=%b want 1/00001/0",
                  m_valid[0][8'h23], m_tag[0][8'h23], m_dirty[0][8'h23]);
      end
      n_tests++;
      if (miss_cnt_o !== (PERF ? 32'd1 : 32'd0) || hit_cnt_o !== 32'd0) begin
         n_fail++;
         $display("FAIL cold_cnt: hit=%0d miss=%0d", hit_cnt_o, miss_cnt_o);
      end
   endtask

   task automatic test_load_hit();
      logic [31:0] rd; logic [7:0] den; int lat, rb;
      cpu(1'b0, 32'h0000_1234, 4'h0, 32'h0, rd, den, lat, rb);
      n_tests++;
      if (lat !== 1 || rd !== B || rb !== 0) begin
         n_fail++;
         $display("FAIL load_hit: lat=%0d data=%h rdy=%0d want 1/%h/0",
                  lat, rd, rb, B);
      end
      n_tests++;
      if (rd_cnt !== 1 || m_lru[8'h23] !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_side: rd=%0d lru=%b want 1/1",
                  rd_cnt, m_lru[8'h23]);
      end
      n_tests++;
      if (hit_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
         n_fail++;
         $display("FAIL hit_cnt: got %0d", hit_cnt_o);
      end
   endtask

   task automatic test_store_hit();
      logic [31:0] rd; logic [7:0] den; int lat, rb;
      cpu(1'b1, 32'h0000_1234, 4'b0011, 32'hAABB_CCDD, rd, den, lat, rb);
      n_tests++;
      if (lat !== 1 || den !== 8'h02) begin
         n_fail++;
         $display("FAIL store_hit: lat=%0d den=%h want 1/02", lat, den);
      end
      @(negedge clk);
      n_tests++;
      if (m_data[0][8'h23] !== {D, C, B[31:16], 16'hCCDD, A} ||
          m_dirty[0][8'h23] !== 1'b1) begin
         n_fail++;
         $display("FAIL store_data: line=%h d=%b",
                  m_data[0][8'h23], m_dirty[0][8'h23]);
      end
   endtask

   task automatic test_evict();
      logic [31:0] rd; logic [7:0] den; int lat, rb;
      ret_line = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
      cpu(1'b0, 32'h0010_1234, 4'h0, 32'h0, rd, den, lat, rb);
      n_tests++;
      if (lat !== 5 || rd !== 32'h2000_0001 || wr_cnt !== 0 ||
          m_tag[1][8'h23] !== 20'h00101) begin
         n_fail++;
         $display("FAIL evict_fill1: lat=%0d data=%h wr=%0d tag1=%h",
                  lat, rd, wr_cnt, m_tag[1][8'h23]);
      end
      ret_line = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
      cpu(1'b0, 32'h0020_1234, 4'h0, 32'h0, rd, den, lat, rb);
      n_tests++;
      if (wr_cnt !== 1 || wr_addr_log !== 32'h0000_1230) begin
         n_fail++;
         $display("FAIL evict_wb_addr: wr=%0d addr=%h want 1/00001230",
                  wr_cnt, wr_addr_log);
      end
      n_tests++;
      if (wr_data_log !== {D, C, B[31:16], 16'hCCDD, A}) begin
         n_fail++;
         $display("FAIL evict_wb_data: got %h", wr_data_log);
      end
      n_tests++;
      if (lat !== 6 || rd !== 32'h3000_0001 ||
          rd_addr_log !== 32'h0020_1230 || rb !== 0) begin
         n_fail++;
         $display("FAIL evict_load: lat=%0d data=%h addr=%h rdy=%0d",
                  lat, rd, rd_addr_log, rb);
      end
      n_tests++;
      if (m_tag[0][8'h23] !== 20'h00201 || m_dirty[0][8'h23] !== 1'b0) begin
         n_fail++;
         $display("FAIL evict_refill: tag0=%h d=%b want 00201/0",
                  m_tag[0][8'h23], m_dirty[0][8'h23]);
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd; logic [7:0] den; int lat, rb;
      logic [31:0] wa0, ra0; logic [127:0] wd0;
      int wcyc, rcyc, unstable;
      ret_line = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
      cpu(1'b1, 32'h0000_5240, 4'hF, 32'h1234_5678, rd, den, lat, rb);
      n_tests++;
      if (lat !== 5 || den !== 8'h01) begin
         n_fail++;
         $display("FAIL store_miss: lat=%0d den=%h want 5/01", lat, den);
      end
      ret_line = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
      cpu(1'b1, 32'h0000_6240, 4'b1000, 32'hEE00_0000, rd, den, lat, rb);
      ret_line = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
      wr_delay = 10; rd_delay = 10;
      wa0 = '0; wd0 = '0; ra0 = '0; wcyc = 0; rcyc = 0; unstable = 0;
      lat = 0; rb = 0; rd = '0;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0;
      bus.req_addr_i = 32'h0000_7240;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.req_ready_o) rb++;
         if (bus.mem_wr_req_o) begin
            if (wcyc == 0) begin
               wa0 = bus.mem_wr_addr_o; wd0 = bus.mem_wr_data_o;
            end else if (bus.mem_wr_addr_o !== wa0 ||
                         bus.mem_wr_data_o !== wd0) unstable++;
            wcyc++;
         end
         if (bus.mem_rd_req_o) begin
            if (rcyc == 0) ra0 = bus.mem_rd_addr_o;
            else if (bus.mem_rd_addr_o !== ra0) unstable++;
            rcyc++;
         end
         if (bus.resp_valid_o) begin
            lat = i; rd = bus.resp_rdata_o;
            break;
         end
      end
      wr_delay = 0; rd_delay = 0;
      n_tests++;
      if (wcyc !== 11 || rcyc !== 11 || unstable !== 0 || rb !== 0) begin
         n_fail++;
         $display("FAIL stall_hold: wcyc=%0d rcyc=%0d unstable=%0d rdy=%0d",
                  wcyc, rcyc, unstable, rb);
      end
      n_tests++;
      if (wa0 !== 32'h0000_5240 ||
          wd0 !== {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL stall_wb: addr=%h data=%h", wa0, wd0);
      end
      n_tests++;
      if (lat !== 26 || rd !== 32'h7777_0000 || ra0 !== 32'h0000_7240) begin
         n_fail++;
         $display("FAIL stall_load: lat=%0d data=%h raddr=%h want 26/77770000",
                  lat, rd, ra0);
      end
      n_tests++;
      if (hit_cnt_o !== (PERF ? 32'd2 : 32'd0) ||
          miss_cnt_o !== (PERF ? 32'd6 : 32'd0)) begin
         n_fail++;
         $display("FAIL stall_cnt: hit=%0d miss=%0d", hit_cnt_o, miss_cnt_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic [7:0] den; int lat, rb, start;
      bit seen;
      hold_ret = 1'b1;
      start = rd_cnt; seen = 1'b0;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0;
      bus.req_addr_i = 32'h0000_8000;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rd_cnt != start) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL rst_mid_reach: no read handshake within 50 cycles");
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.req_ready_o !== 1'b1 || bus.mem_rd_req_o !== 1'b0 ||
          bus.mem_wr_req_o !== 1'b0 || bus.resp_valid_o !== 1'b0 ||
          way_index_o !== 8'h0 || hit_cnt_o !== 32'h0 ||
          miss_cnt_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_out: ready=%b rd=%b wr=%b idx=%h hit=%0d miss=%0d",
                  bus.req_ready_o, bus.mem_rd_req_o, bus.mem_wr_req_o,
                  way_index_o, hit_cnt_o, miss_cnt_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      hold_ret = 1'b0;
      ret_line = {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000};
      cpu(1'b0, 32'h0000_8000, 4'h0, 32'h0, rd, den, lat, rb);
      n_tests++;
      if (lat !== 5 || rd !== 32'h8888_0000 || rd_addr_log !== 32'h0000_8000) begin
         n_fail++;
         $display("FAIL rst_mid_fresh: lat=%0d data=%h addr=%h want 5/88880000",
                  lat, rd, rd_addr_log);
      end
      n_tests++;
      if (miss_cnt_o !== (PERF ? 32'd1 : 32'd0) || hit_cnt_o !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid_cnt: hit=%0d miss=%0d", hit_cnt_o, miss_cnt_o);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0;
      bus.req_addr_i = '0; bus.req_wstrb_i = '0; bus.req_wdata_i = '0;
      repeat (3) @(posedge clk);
      test_reset();
      test_cold_load();
      test_load_hit();
      test_store_hit();
      test_evict();
      test_stall();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
